// File: rtl/ctrl_pipe_pkg.sv
// Shared defaults and helpers for the ctrl_pipe control-word pipeline.
// Optional performance counters are enabled with CTRL_PIPE_PERF_EN.
package ctrl_pipe_pkg;

  localparam int CW_DEF      = 16;
  localparam int NSTAGES_DEF = 4;
  localparam int CNT_W_DEF   = 16;
  localparam logic [CW_DEF-1:0] NOP_DEF = '0;

  typedef logic [CW_DEF-1:0] ctrl_word_t;

  // Bits needed to hold values 0..n-1 (at least 1).
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control-word register stage with flush, hold and bubble insertion.
// Priority: flush, then hold, then bubble, then load from source.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int            CW       = CW_DEF,
  parameter logic [CW-1:0] NOP_WORD = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          src_valid,
  input  logic [CW-1:0] src_ctrl,
  input  logic          load_bubble,
  input  logic          hold,
  input  logic          flush,
  output logic          valid,
  output logic [CW-1:0] ctrl
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= NOP_WORD;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= NOP_WORD;
    end else if (hold) begin
      valid <= valid;
      ctrl  <= ctrl;
    end else if (load_bubble || !src_valid) begin
      valid <= 1'b0;
      ctrl  <= NOP_WORD;
    end else begin
      valid <= 1'b1;
      ctrl  <= src_ctrl;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Multi-stage control-word pipeline with per-stage stall and flush.
// Define CTRL_PIPE_PERF_EN to build the bubble/flush counters.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int            CW       = CW_DEF,
  parameter int            NSTAGES  = NSTAGES_DEF,
  parameter logic [CW-1:0] NOP_WORD = '0,
  parameter int            CNT_W    = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [CW-1:0]         in_ctrl,
  output logic                  in_ready,
  input  logic [NSTAGES-1:0]    stall,
  input  logic [NSTAGES-1:0]    flush,
  output logic [NSTAGES-1:0]    stage_valid,
  output logic [NSTAGES*CW-1:0] stage_ctrl,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic [NSTAGES-1:0] hold;
  logic [NSTAGES-1:0] load_bubble;

  // A stall freezes its own stage and every earlier one.
  always_comb begin
    hold = '0;
    hold[NSTAGES-1] = stall[NSTAGES-1];
    for (int i = NSTAGES - 2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
  end

  always_comb begin
    load_bubble = '0;
    for (int i = 1; i < NSTAGES; i++) begin
      load_bubble[i] = hold[i-1] & ~hold[i];
    end
  end

  assign in_ready = ~hold[0];

  genvar g;
  generate
    for (g = 0; g < NSTAGES; g++) begin : g_stage
      logic          src_valid;
      logic [CW-1:0] src_ctrl;

      if (g == 0) begin : g_head
        assign src_valid = in_valid;
        assign src_ctrl  = in_ctrl;
      end else begin : g_body
        assign src_valid = stage_valid[g-1];
        assign src_ctrl  = stage_ctrl[(g-1)*CW +: CW];
      end

      ctrl_pipe_stage #(
        .CW       (CW),
        .NOP_WORD (NOP_WORD)
      ) u_stage (
        .clock       (clock),
        .reset       (reset),
        .src_valid   (src_valid),
        .src_ctrl    (src_ctrl),
        .load_bubble (load_bubble[g]),
        .hold        (hold[g]),
        .flush       (flush[g]),
        .valid       (stage_valid[g]),
        .ctrl        (stage_ctrl[g*CW +: CW])
      );
    end
  endgenerate

`ifdef CTRL_PIPE_PERF_EN
  localparam int SW = idx_w(NSTAGES + 1);

  logic [SW-1:0]       bub_n;
  logic [SW-1:0]       fl_n;
  logic [CNT_W+SW-1:0] bsum;
  logic [CNT_W+SW-1:0] fsum;

  // A flushed stage is squashed, so it does not also count as a bubble.
  always_comb begin
    bub_n = '0;
    fl_n  = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      bub_n = bub_n + SW'(load_bubble[i] & ~flush[i]);
      fl_n  = fl_n + SW'(flush[i] & stage_valid[i]);
    end
  end

  assign bsum = {{SW{1'b0}}, bubble_cnt} + {{CNT_W{1'b0}}, bub_n};
  assign fsum = {{SW{1'b0}}, flush_cnt} + {{CNT_W{1'b0}}, fl_n};

  always_ff @(posedge clock) begin
    if (reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (|bsum[CNT_W+SW-1:CNT_W]) bubble_cnt <= '1;
      else bubble_cnt <= bsum[CNT_W-1:0];
      if (|fsum[CNT_W+SW-1:CNT_W]) flush_cnt <= '1;
      else flush_cnt <= fsum[CNT_W-1:0];
    end
  end
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus random traffic
// compared against an array-based reference model of the pipeline rules.
module tb_ctrl_pipe;

  localparam int CW    = 16;
  localparam int NS    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic [CW-1:0]     in_ctrl;
  logic              in_ready;
  logic [NS-1:0]     stall;
  logic [NS-1:0]     flush;
  logic [NS-1:0]     stage_valid;
  logic [NS*CW-1:0]  stage_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  ctrl_pipe #(
    .CW       (CW),
    .NSTAGES  (NS),
    .NOP_WORD ('0),
    .CNT_W    (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ctrl     (in_ctrl),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .stage_valid (stage_valid),
    .stage_ctrl  (stage_ctrl),
    .bubble_cnt  (bubble_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  bit          mv[NS];
  logic [CW-1:0] mc[NS];
  int          mbub;
  int          mfl;

`ifdef CTRL_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit held(input int i, input logic [NS-1:0] st);
    for (int j = i; j < NS; j++) if (st[j]) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the applied inputs.
  task automatic model_step();
    bit          nv[NS];
    logic [CW-1:0] nc[NS];
    int nb, nf;
    nb = 0;
    nf = 0;
    for (int i = 0; i < NS; i++) begin
      if (flush[i]) begin
        if (mv[i]) nf++;
        nv[i] = 0; nc[i] = '0;
      end else if (held(i, stall)) begin
        nv[i] = mv[i]; nc[i] = mc[i];
      end else if (i == 0) begin
        nv[i] = in_valid;
        nc[i] = in_valid ? in_ctrl : '0;
      end else if (held(i - 1, stall)) begin
        nb++;
        nv[i] = 0; nc[i] = '0;
      end else begin
        nv[i] = mv[i-1]; nc[i] = mc[i-1];
      end
    end
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        mv[i] = 0; mc[i] = '0;
      end
      mbub = 0;
      mfl  = 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        mv[i] = nv[i]; mc[i] = nc[i];
      end
      mbub = (mbub + nb > CMAX) ? CMAX : mbub + nb;
      mfl  = (mfl + nf > CMAX) ? CMAX : mfl + nf;
    end
  endtask

  task automatic compare_all();
    logic [NS-1:0]    ev;
    logic [NS*CW-1:0] ec;
    for (int i = 0; i < NS; i++) begin
      ev[i] = mv[i];
      ec[i*CW +: CW] = mc[i];
    end
    check("stage_valid", 64'(stage_valid), 64'(ev));
    check("stage_ctrl", 64'(stage_ctrl), 64'(ec));
    check("bubble_cnt", 64'(bubble_cnt), PERF ? 64'(mbub) : 64'd0);
    check("flush_cnt", 64'(flush_cnt), PERF ? 64'(mfl) : 64'd0);
  endtask

  task automatic cyc(input logic iv, input logic [CW-1:0] ic,
                     input logic [NS-1:0] st, input logic [NS-1:0] fl,
                     input logic rs);
    in_valid = iv;
    in_ctrl  = ic;
    stall    = st;
    flush    = fl;
    reset    = rs;
    #1;
    check("in_ready", 64'(in_ready), 64'(!(|st)));
    @(posedge clock);
    #1;
    model_step();
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      mv[i] = 0; mc[i] = '0;
    end
    mbub = 0;
    mfl  = 0;
    @(posedge clock);
    #1;

    // Reset
    cyc(1'b1, 16'hBEEF, '0, '0, 1'b1);
    cyc(1'b0, 16'h0000, '0, '0, 1'b1);
    check("reset_valid", 64'(stage_valid), 64'd0);

    // Stream 1..5, word 1 in stage 3 after the 4th edge
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, CW'(k), '0, '0, 1'b0);
      if (k == 4) begin
        check("lat_ctrl3", 64'(stage_ctrl[3*CW +: CW]), 64'h0001);
        check("lat_valid3", 64'(stage_valid[3]), 64'd1);
      end
    end

    // Stall stage 1 for two cycles
    cyc(1'b1, 16'h0006, 4'b0010, '0, 1'b0);
    cyc(1'b1, 16'h0007, 4'b0010, '0, 1'b0);
    check("stall_bubble2", 64'(stage_valid[2]), 64'd0);
    cyc(1'b1, 16'h0008, '0, '0, 1'b0);
    cyc(1'b1, 16'h0009, '0, '0, 1'b0);
    cyc(1'b1, 16'h000A, '0, '0, 1'b0);

    // Flush stages 0 and 1
    cyc(1'b1, 16'h000B, '0, 4'b0011, 1'b0);
    check("flush_s1", 64'(stage_ctrl[1*CW +: CW]), 64'h0000);
    cyc(1'b1, 16'h000C, '0, '0, 1'b0);

    // Stall and flush on stage 2 together
    cyc(1'b1, 16'h000D, '0, '0, 1'b0);
    cyc(1'b1, 16'h000E, '0, '0, 1'b0);
    cyc(1'b1, 16'h000F, 4'b0100, 4'b0100, 1'b0);
    check("sf_s2", 64'(stage_valid[2]), 64'd0);
    cyc(1'b1, 16'h0010, '0, '0, 1'b0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [NS-1:0] st, fl;
      for (int b = 0; b < NS; b++) begin
        st[b] = ($urandom_range(0, 5) == 0);
        fl[b] = ($urandom_range(0, 7) == 0);
      end
      cyc(1'($urandom), CW'($urandom), st, fl,
          $urandom_range(0, 49) == 0);
    end

    // Saturate the bubble counter
    cyc(1'b0, 16'h0000, '0, '0, 1'b1);
    for (int n = 0; n < 20; n++) cyc(1'b1, CW'(n), 4'b0001, '0, 1'b0);
    check("bub_sat", 64'(bubble_cnt), PERF ? 64'hF : 64'd0);

    // Reset mid-stream with a stall active
    for (int k = 0; k < 5; k++) cyc(1'b1, CW'(16'h100 + k), '0, '0, 1'b0);
    cyc(1'b1, 16'h0200, 4'b1000, 4'b0001, 1'b1);
    check("rst_valid", 64'(stage_valid), 64'd0);
    check("rst_ctrl", 64'(stage_ctrl), 64'd0);
    check("rst_bub", 64'(bubble_cnt), 64'd0);
    cyc(1'b1, 16'h0201, '0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
